// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// ID-stage hazard scoreboard. Tracks in-flight writers in a shadow pipeline
// of DEPTH slots (slot 0 = EXE ... slot DEPTH-1 = WB). From that state it
// decides, per source operand, whether ID must stall and, in forwarding mode,
// which stage the operand is taken from. A saturating counter records the
// number of cycles spent stalled.
module hazard_scoreboard #(
  parameter int ADDR_W     = 4,   // register address width
  parameter int DEPTH      = 3,   // shadow slots after ID, 2..7
  parameter int LOAD_STAGE = 1,   // first slot where load data can be forwarded
  parameter int SEL_W      = 3,   // forwarding select width, 2**SEL_W > DEPTH
  parameter int CNT_W      = 16   // stall counter width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fwd_en,
  input  logic              ignore_hazard,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              two_src,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              freeze,
  output logic              hazard_detected,
  output logic [SEL_W-1:0]  fwd_sel1,
  output logic [SEL_W-1:0]  fwd_sel2,
  output logic [CNT_W-1:0]  stall_count
);

  // Shadow pipeline state, one entry per stage after ID.
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_wb_en;
  logic [DEPTH-1:0]  r_mem_read;
  logic [ADDR_W-1:0] r_dest [DEPTH];
  logic [CNT_W-1:0]  r_stall_cnt;

  // Per-slot match vectors for each source operand.
  logic [DEPTH-1:0]  w_match1;
  logic [DEPTH-1:0]  w_match2;

  // Resolved per-source decisions: {hazard, select}.
  logic [SEL_W:0]    w_res1;
  logic [SEL_W:0]    w_res2;
  logic              w_hazard;
  logic              w_issue;

  // A slot matches a source when it holds a live writer of that register.
  // Operand-use gating (two_src) is applied later, in resolve().
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign w_match1[gi] = r_valid[gi] & r_wb_en[gi] & (r_dest[gi] == src1);
    assign w_match2[gi] = r_valid[gi] & r_wb_en[gi] & (r_dest[gi] == src2);
  end

  // Turn a match vector into a {hazard, fwd_sel} pair. The scan runs from
  // the oldest slot towards slot 0 so the youngest (lowest index) match is
  // the one left standing, which is the value the program actually expects.
  function automatic logic [SEL_W:0] resolve(
    input logic [DEPTH-1:0] match,
    input logic             used,
    input logic             fwd,
    input logic [DEPTH-1:0] is_load
  );
    logic             found;
    int               youngest;
    logic             haz;
    logic [SEL_W-1:0] sel;
    found    = 1'b0;
    youngest = 0;
    haz      = 1'b0;
    sel      = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (match[s]) begin
        found    = 1'b1;
        youngest = s;
      end
    end
    if (used && found) begin
      if (!fwd) begin
        // Without forwarding, only the WB slot is safe: the register file
        // writes in the first half-cycle, so ID reads the new value.
        haz = (youngest <= DEPTH - 2);
      end else if (is_load[youngest] && (youngest < LOAD_STAGE)) begin
        // Load data does not exist yet at this stage: wait for it.
        haz = 1'b1;
      end else begin
        sel = SEL_W'(youngest) + SEL_W'(1);
      end
    end
    return {haz, sel};
  endfunction

  // Per-source resolution and the combined stall decision.
  always_comb begin
    w_res1   = resolve(w_match1, 1'b1,    fwd_en, r_mem_read);
    w_res2   = resolve(w_match2, two_src, fwd_en, r_mem_read);
    w_hazard = !ignore_hazard & id_valid & (w_res1[SEL_W] | w_res2[SEL_W]);
    // A stalled or flushed ID instruction leaves a bubble behind it.
    w_issue  = id_valid & !w_hazard & !flush;
  end

  assign hazard_detected = w_hazard;
  assign fwd_sel1        = w_res1[SEL_W-1:0];
  assign fwd_sel2        = w_res2[SEL_W-1:0];
  assign stall_count     = r_stall_cnt;

  // Advance the shadow pipeline; freeze holds every slot in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_wb_en    <= '0;
      r_mem_read <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dest[i] <= '0;
      end
    end else if (!freeze) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i]    <= r_valid[i-1];
        r_wb_en[i]    <= r_wb_en[i-1];
        r_mem_read[i] <= r_mem_read[i-1];
        r_dest[i]     <= r_dest[i-1];
      end
      r_valid[0]    <= w_issue;
      r_wb_en[0]    <= w_issue & id_wb_en;
      r_mem_read[0] <= w_issue & id_mem_read;
      r_dest[0]     <= id_dest;
    end
  end

  // Count stall cycles, saturating at the all-ones value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !freeze && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard detector.
- Keeps its own shadow pipeline of in-flight writers; ID no longer supplies EXE/MEM destinations.
- Per-source decisions from that state: stall, or forward and from which stage.
- Adds configurable pipeline depth, configurable load-result stage, pipeline freeze/flush, and a saturating stall-cycle performance counter.

Parameters:
- ADDR_W, 4, register address width.
- DEPTH, 3, shadow slots after ID (slot 0 = EXE … slot DEPTH-1 = WB); legal range 2..7.
- LOAD_STAGE, 1, first slot index at which load data is forwardable (1 = MEM); must be < DEPTH.
- SEL_W, 3, forwarding-select width; must satisfy 2^SEL_W > DEPTH.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode
- ignore_hazard  in  1  forces hazard_detected=0 (no-source instructions)
- id_valid  in  1  ID holds a real instruction
- src1  in  ADDR_W  first source register
- src2  in  ADDR_W  second source register
- two_src  in  1  src2 is used
- id_dest  in  ADDR_W  ID instruction destination
- id_wb_en  in  1  ID instruction writes id_dest
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  branch taken; ID instruction is killed
- freeze  in  1  whole pipeline held (memory wait)
- hazard_detected  out  1  stall ID/IF this cycle
- fwd_sel1  out  SEL_W  src1 operand source: 0 = register file, k = slot k-1
- fwd_sel2  out  SEL_W  src2 operand source, same encoding
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Slot state: valid, wb_en, mem_read, dest.
- Reset (async, immediate): all slots invalid, stall_count=0. Hence hazard_detected=0 and fwd_sel1/2=0 while rst is high and after release until a writer issues.
- Slot update on rising clk:
  - freeze=1: all slots and the counter hold.
  - Otherwise slot i ← slot i-1 for i≥1, and slot 0 ← ID entry if id_valid & !hazard_detected & !flush; else bubble (valid=0).
- Match(s, r): slot s valid & wb_en & dest==r. src2 is considered only when two_src=1. The youngest slot (lowest index) wins.
- Stall-only mode (fwd_en=0):
  - Hazard if any match in slots 0..DEPTH-2 for either considered source.
  - The WB slot is excluded: the register file writes before read.
  - fwd_sel1/2 = 0.
- Forwarding mode (fwd_en=1): for each considered source, take the youngest matching slot s in 0..DEPTH-1.
  - s is a load with s < LOAD_STAGE → hazard; fwd_sel = 0.
  - Otherwise fwd_sel = s+1.
  - No match → fwd_sel = 0.
- hazard_detected = !ignore_hazard & id_valid & (src1 hazard | src2 hazard). Combinational from slot state plus ID inputs; no added latency.
- fwd_sel outputs are valid regardless of ignore_hazard. Consumers ignore them when stalled.
- Unused source (two_src=0): fwd_sel2 = 0.
- stall_count increments on clk when hazard_detected & !freeze, saturating at 2^CNT_W-1.
- flush with hazard in the same cycle: bubble enters slot 0; hazard still reported. The PC redirect takes precedence outside this block.
- freeze with hazard: outputs keep tracking held state; no counter increment.
- Reset mid-operation discards all in-flight entries; no residual stall after release.

Test Plan:
- ALU chain (DEPTH=3, fwd_en=1): issue ADD r2 (wb_en), next cycle ID src1=r2 → hazard_detected=0, fwd_sel1=1. One cycle later the same source → fwd_sel1=2. One more cycle (now in WB) → fwd_sel1=3.
- Load-use: LDR r4 issued, next ID src2=r4, two_src=1 → hazard=1 for exactly 1 cycle, stall_count 0→1. Then fwd_sel2=2, hazard=0. With LOAD_STAGE=2 the stall lasts 2 cycles and stall_count=2.
- Stall-only mode: ADD r1 then src1=r1 → hazard for 2 cycles (slots 0 and 1), then fwd_sel1=0, hazard=0. Same sequence with two_src=0 and src2=r1 → no hazard.
- Priority: ADD r5 issued, then SUB r5 issued, then ID src1=r5 → fwd_sel1=1 (younger SUB), not 2.
- Freeze and flush:
  - Load in slot 0, freeze=1 for 3 cycles → hazard stays 1, stall_count unchanged. After release it stalls once more, then hazard=0.
  - flush=1 on a writer of r7 → bubble; next ID src1=r7 → fwd_sel1=0.
- Reset and saturation:
  - Assert rst asynchronously with two valid writers in flight → hazard_detected and fwd_sel drop to 0 immediately.
  - With CNT_W=4, sustain 20 stall cycles → stall_count sticks at 15.
